// File: rtl/ledsegment_pkg.sv
// Shared types and constants for the seven-segment address capture stage.
package ledsegment_pkg;

  localparam int ADDR_W          = 21;
  localparam int DEF_HOLD_CYCLES = 2_800_000;
  localparam int DEF_DEB_CYCLES  = 65_536;
  localparam int NUM_BTN         = 3;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

endpackage

// File: rtl/ledsegment_debounce.sv
// Button conditioning: 2-FF synchroniser, stable-level debouncer, and a
// registered one-cycle pulse on each accepted press.
module ledsegment_debounce
  import ledsegment_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  output logic pulse
);

  localparam int CNTW = $clog2(DEB_CYCLES + 1);

  logic            sync1_reg, sync2_reg;
  logic            deb_reg, deb_prev_reg, pulse_reg;
  logic [CNTW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      deb_reg      <= 1'b0;
      deb_prev_reg <= 1'b0;
      pulse_reg    <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= btn;
      sync2_reg    <= sync1_reg;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2_reg != deb_reg) begin
        if (cnt_reg == CNTW'(DEB_CYCLES - 1)) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNTW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
      deb_prev_reg <= deb_reg;
      pulse_reg    <= deb_reg & ~deb_prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/ledsegment_addrcapture.sv
// Captures CPU addresses on a strobe, rate-limits display updates and keeps a
// small history that the board buttons can freeze and browse.
module ledsegment_addrcapture
  import ledsegment_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int DEPTH       = 8
) (
  input  logic                     clk_peripheral,
  input  logic                     peripheral_reset,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_strobe,
  input  logic                     btn_freeze,
  input  logic                     btn_back,
  input  logic                     btn_fwd,
  output logic [ADDR_W-1:0]        address,
  output logic                     frozen,
  output logic [$clog2(DEPTH)-1:0] hist_index
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES);

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               freeze_p, back_p, fwd_p;

  assign btn_raw  = {btn_fwd, btn_back, btn_freeze};
  assign freeze_p = btn_pulse[0];
  assign back_p   = btn_pulse[1];
  assign fwd_p    = btn_pulse[2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      ledsegment_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk_peripheral),
        .srst  (peripheral_reset),
        .btn   (btn_raw[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [IW-1:0]     offset_reg, offset_next, wr_reg, wr_next, off_new;
  logic [CW-1:0]     count_reg, count_next, off_inc;
  logic [HW-1:0]     hold_reg, hold_next;
  logic              pending_reg, pending_next, push;
  logic [ADDR_W-1:0] latest_reg, latest_next, address_reg, address_next;
  logic [ADDR_W-1:0] hist [DEPTH];

  always_comb begin
    state_next   = state_reg;
    offset_next  = offset_reg;
    wr_next      = wr_reg;
    count_next   = count_reg;
    hold_next    = hold_reg;
    pending_next = pending_reg;
    latest_next  = latest_reg;
    address_next = address_reg;
    off_inc      = CW'(offset_reg) + CW'(1);
    off_new      = offset_reg;
    push         = (state_reg == ST_LIVE) && (hold_reg == '0) && pending_reg;

    if (push) begin
      wr_next      = wr_reg + IW'(1);
      if (count_reg != CW'(DEPTH)) count_next = count_reg + CW'(1);
      address_next = latest_reg;
      pending_next = 1'b0;
      hold_next    = HW'(HOLD_CYCLES - 1);
    end else if (hold_reg != '0) begin
      hold_next = hold_reg - HW'(1);
    end

    // A strobe coinciding with a push re-arms pending for the next push.
    if (mem_strobe) begin
      latest_next  = mem_addr;
      pending_next = 1'b1;
    end

    case (state_reg)
      ST_LIVE: begin
        if (freeze_p) begin
          state_next  = ST_FROZEN;
          offset_next = '0;
        end
      end
      ST_FROZEN: begin
        if (freeze_p) begin
          state_next  = ST_LIVE;
          offset_next = '0;
          hold_next   = '0;
        end else if ((count_reg != '0) && (back_p ^ fwd_p)) begin
          if (back_p)
            off_new = (off_inc > count_reg - CW'(1)) ? IW'(count_reg - CW'(1)) : IW'(off_inc);
          else
            off_new = (offset_reg == '0) ? '0 : offset_reg - IW'(1);
          offset_next  = off_new;
          address_next = hist[wr_reg - IW'(1) - off_new];
        end
      end
      default: state_next = ST_LIVE;
    endcase
  end

  always_ff @(posedge clk_peripheral) begin
    if (peripheral_reset) begin
      state_reg   <= ST_LIVE;
      offset_reg  <= '0;
      wr_reg      <= '0;
      count_reg   <= '0;
      hold_reg    <= '0;
      pending_reg <= 1'b0;
      latest_reg  <= '0;
      address_reg <= '0;
    end else begin
      state_reg   <= state_next;
      offset_reg  <= offset_next;
      wr_reg      <= wr_next;
      count_reg   <= count_next;
      hold_reg    <= hold_next;
      pending_reg <= pending_next;
      latest_reg  <= latest_next;
      address_reg <= address_next;
    end
  end

  // History contents are unreachable after reset because count restarts at 0.
  always_ff @(posedge clk_peripheral) begin
    if (push && !peripheral_reset) hist[wr_reg] <= latest_reg;
  end

  assign address    = address_reg;
  assign frozen     = (state_reg == ST_FROZEN);
  assign hist_index = offset_reg;

endmodule

// File: tb/tb_ledsegment_addrcapture.sv
// Self-checking bench for ledsegment_addrcapture with short hold/debounce times.
module tb_ledsegment_addrcapture;
  import ledsegment_pkg::*;

  localparam int HOLD  = 4;
  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        peripheral_reset = 1'b0;
  logic [20:0] mem_addr = '0;
  logic        mem_strobe = 1'b0;
  logic        btn_freeze = 1'b0, btn_back = 1'b0, btn_fwd = 1'b0;
  logic [20:0] address;
  logic        frozen;
  logic [2:0]  hist_index;

  ledsegment_addrcapture #(.HOLD_CYCLES(HOLD), .DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
    .clk_peripheral   (clk),
    .peripheral_reset (peripheral_reset),
    .mem_addr         (mem_addr),
    .mem_strobe       (mem_strobe),
    .btn_freeze       (btn_freeze),
    .btn_back         (btn_back),
    .btn_fwd          (btn_fwd),
    .address          (address),
    .frozen           (frozen),
    .hist_index       (hist_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: history as a queue (newest at back), push timing as a
  // timestamp, button presses recognised from the length of the raw high run.
  bit          m_live = 1'b1;
  int          m_off = 0;
  logic [20:0] m_addr = '0, m_latest = '0;
  bit          m_pending = 1'b0;
  int          m_ready = 0;
  int          e = 0;
  int          run [3] = '{0, 0, 0};
  logic [20:0] m_hist [$];
  bit          rnd_stb = 1'b0;

  typedef struct {
    bit          rst;
    bit          stb;
    logic [20:0] a;
    logic [20:0] ea;
  } vec_t;
  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit s, input logic [20:0] a, input bit [2:0] raw);
    bit [2:0] p;
    bit push;
    int sz;
    e++;
    if (rst) begin
      m_hist.delete();
      m_live = 1'b1; m_off = 0; m_addr = '0; m_latest = '0; m_pending = 1'b0;
      m_ready = e + 1;
      for (int b = 0; b < 3; b++) run[b] = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      run[b] = raw[b] ? run[b] + 1 : 0;
      p[b] = (run[b] == DEB + 4);
    end
    push = m_live && m_pending && (e >= m_ready);
    if (push) begin
      m_hist.push_back(m_latest);
      if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
      m_addr = m_latest;
      m_ready = e + HOLD;
      m_pending = 1'b0;
    end
    if (s) begin
      m_latest = a;
      m_pending = 1'b1;
    end
    sz = m_hist.size();
    if (m_live) begin
      if (p[0]) begin m_live = 1'b0; m_off = 0; end
    end else if (p[0]) begin
      m_live = 1'b1; m_off = 0; m_ready = e + 1;
    end else if (sz > 0 && p[1] != p[2]) begin
      if (p[1]) m_off = (m_off + 1 > sz - 1) ? sz - 1 : m_off + 1;
      else      m_off = (m_off > 0) ? m_off - 1 : 0;
      m_addr = m_hist[sz - 1 - m_off];
    end
  endtask

  task automatic step(input bit rst, input bit s, input logic [20:0] a, input bit [2:0] raw);
    peripheral_reset = rst;
    mem_strobe = s;
    mem_addr = a;
    {btn_fwd, btn_back, btn_freeze} = raw;
    @(posedge clk);
    model_edge(rst, s, a, raw);
    @(negedge clk);
    checks++;
    if (address !== m_addr || frozen !== !m_live || hist_index !== 3'(m_off)) begin
      failures++;
      $display("FAIL model e=%0d address got=%h exp=%h frozen got=%0b exp=%0b hist_index got=%0d exp=%0d",
               e, address, m_addr, frozen, !m_live, hist_index, m_off);
    end
  endtask

  task automatic gen_step(input bit [2:0] raw);
    if (rnd_stb) step(1'b0, $urandom_range(0, 3) == 0, 21'($urandom), raw);
    else         step(1'b0, 1'b0, '0, raw);
  endtask

  task automatic press(input bit [2:0] m);
    repeat (DEB + 6) gen_step(m);
    repeat (DEB + 6) gen_step(3'b000);
    $display("press mask=%b frozen=%0b hist_index=%0d address=%h", m, frozen, hist_index, address);
  endtask

  initial begin
    int toggles, first, idx;
    bit prev;
    bit pat [5];

    vec[0]  = '{1'b1, 1'b0, 21'h00000, 21'h00000};
    vec[1]  = '{1'b0, 1'b1, 21'h1ABCD, 21'h00000};
    vec[2]  = '{1'b0, 1'b0, 21'h00000, 21'h1ABCD};
    vec[3]  = '{1'b0, 1'b1, 21'h00010, 21'h1ABCD};
    vec[4]  = '{1'b0, 1'b1, 21'h00020, 21'h1ABCD};
    vec[5]  = '{1'b0, 1'b1, 21'h00030, 21'h1ABCD};
    vec[6]  = '{1'b0, 1'b0, 21'h00000, 21'h00030};
    vec[7]  = '{1'b0, 1'b1, 21'h00040, 21'h00030};
    vec[8]  = '{1'b0, 1'b0, 21'h00000, 21'h00030};
    vec[9]  = '{1'b0, 1'b0, 21'h00000, 21'h00030};
    vec[10] = '{1'b0, 1'b1, 21'h00050, 21'h00040};
    vec[11] = '{1'b0, 1'b0, 21'h00000, 21'h00040};
    vec[12] = '{1'b0, 1'b0, 21'h00000, 21'h00040};
    vec[13] = '{1'b0, 1'b0, 21'h00000, 21'h00040};
    vec[14] = '{1'b0, 1'b0, 21'h00000, 21'h00050};
    vec[15] = '{1'b0, 1'b0, 21'h00000, 21'h00050};

    // Reset, strobe latency, hold window, push+strobe in the same cycle.
    for (int i = 0; i < 16; i++) begin
      step(vec[i].rst, vec[i].stb, vec[i].a, 3'b000);
      checks++;
      if (address !== vec[i].ea || frozen !== 1'b0 || hist_index !== 3'd0) begin
        failures++;
        $display("FAIL vec%0d address got=%h exp=%h frozen got=%0b hist_index got=%0d", i, address, vec[i].ea, frozen, hist_index);
      end
      $display("vec%0d rst=%0b stb=%0b addr_in=%h address=%h", i, vec[i].rst, vec[i].stb, vec[i].a, address);
    end

    // Ten pushes, freeze, back x9 with saturation at the oldest entry.
    for (int v = 1; v <= 10; v++) begin
      step(1'b0, 1'b1, 21'(v), 3'b000);
      repeat (4) step(1'b0, 1'b0, '0, 3'b000);
    end
    chk("ten_pushes_addr", 32'(address), 32'hA);
    press(3'b001);
    chk("freeze_frozen", 32'(frozen), 1);
    chk("freeze_addr", 32'(address), 32'hA);
    for (int k = 1; k <= 9; k++) begin
      idx = (k > 7) ? 7 : k;
      press(3'b010);
      chk("back_idx", 32'(hist_index), 32'(idx));
      chk("back_addr", 32'(address), 32'(10 - idx));
    end

    // Strobe while frozen, fwd to saturation, both-buttons, freeze wins.
    step(1'b0, 1'b1, 21'h55555, 3'b000);
    chk("frozen_strobe_addr", 32'(address), 32'h3);
    for (int k = 1; k <= 8; k++) begin
      idx = (7 - k < 0) ? 0 : 7 - k;
      press(3'b100);
      chk("fwd_idx", 32'(hist_index), 32'(idx));
      chk("fwd_addr", 32'(address), 32'(10 - idx));
    end
    press(3'b110);
    chk("back_fwd_idx", 32'(hist_index), 0);
    chk("back_fwd_frozen", 32'(frozen), 1);
    press(3'b011);
    chk("unfreeze_frozen", 32'(frozen), 0);
    chk("unfreeze_addr", 32'(address), 32'h55555);
    chk("unfreeze_idx", 32'(hist_index), 0);

    // Bounce on the freeze button followed by a stable press.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    prev = frozen; toggles = 0; first = -1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, {2'b00, pat[i]});
      if (frozen !== prev) begin toggles++; prev = frozen; end
    end
    for (int j = 0; j < DEB + 6; j++) begin
      step(1'b0, 1'b0, '0, 3'b001);
      if (frozen !== prev) begin toggles++; prev = frozen; if (first < 0) first = j; end
    end
    repeat (DEB + 6) begin
      step(1'b0, 1'b0, '0, 3'b000);
      if (frozen !== prev) begin toggles++; prev = frozen; end
    end
    chk("bounce_toggles", 32'(toggles), 1);
    chk("bounce_latency", 32'(first), 32'(DEB + 3));

    // Reset while browsing, then confirm an empty history ignores browsing.
    repeat (3) press(3'b010);
    chk("browse3_idx", 32'(hist_index), 3);
    chk("browse3_addr", 32'(address), 32'h8);
    step(1'b1, 1'b0, '0, 3'b000);
    chk("rst_addr", 32'(address), 0);
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_idx", 32'(hist_index), 0);
    press(3'b010);
    chk("rst_back_idx", 32'(hist_index), 0);
    press(3'b001);
    press(3'b010);
    chk("empty_back_idx", 32'(hist_index), 0);
    chk("empty_back_addr", 32'(address), 0);
    press(3'b001);
    step(1'b0, 1'b1, 21'h12345, 3'b000);
    step(1'b0, 1'b0, '0, 3'b000);
    chk("post_rst_strobe", 32'(address), 32'h12345);

    // Randomised traffic checked cycle by cycle against the model.
    rnd_stb = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0)       press(3'($urandom_range(1, 7)));
      else if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, '0, 3'b000);
      else                                  gen_step(3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
